// File: rtl/rx_pkg.sv
// rx_pkg: shared symbol codes, default widths and saturating arithmetic
//   for the Fs/4 quadrature receiver.
//   SYM_M3/SYM_M1/SYM_P1/SYM_P3 : 2-bit symbol codes (-3,-1,+1,+3), same as transmitter
//   ACC_W_DEFAULT               : default accumulator width
//   IN_W                        : carrier sample width
//   sat_add / sat_neg           : saturating add (to w-bit signed) and negate
package rx_pkg;

    localparam int ACC_W_DEFAULT = 22;
    localparam int IN_W = 18;

    localparam logic [1:0] SYM_M3 = 2'b00;
    localparam logic [1:0] SYM_M1 = 2'b01;
    localparam logic [1:0] SYM_P1 = 2'b10;
    localparam logic [1:0] SYM_P3 = 2'b11;

    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint hi, lo, s;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        s = a + b;
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction

    // The most negative sample has no positive twin; clip it to the max.
    function automatic logic signed [IN_W-1:0] sat_neg(input logic signed [IN_W-1:0] x);
        return (x == {1'b1, {(IN_W-1){1'b0}}}) ? {1'b0, {(IN_W-1){1'b1}}} : -x;
    endfunction

endpackage

// File: rtl/rx_integrate_dump.sv
// rx_integrate_dump: per-rail integrate-and-dump matched filter with 4-level slicer.
//   Optional feature macro: RX_ERR_EN (adds the err output).
//   clk, reset_n      : clock, asynchronous active-low reset
//   sam_clk_ena       : accumulate enable
//   sym_clk_ena       : dump/slice strobe, honoured only with sam_clk_ena
//   mix               : mixed baseband sample for this rail
//   slice_thresh      : unsigned outer decision threshold T
//   sym_out           : registered symbol code
//   err (RX_ERR_EN)   : registered slicer error, sum minus ideal level
module rx_integrate_dump
    import rx_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sam_clk_ena,
    input  logic                   sym_clk_ena,
    input  logic signed [IN_W-1:0] mix,
    input  logic [ACC_W-2:0]       slice_thresh,
    output logic [1:0]             sym_out
`ifdef RX_ERR_EN
    ,
    output logic signed [ACC_W:0]  err
`endif
);

    logic signed [ACC_W-1:0] acc, sum;
    logic signed [ACC_W:0]   s, t;
    logic [1:0]              code;

    assign sum  = ACC_W'(sat_add(longint'(acc), longint'(mix), ACC_W));
    // One extra bit so +T and -T are both representable next to the sum.
    assign s    = (ACC_W+1)'(sum);
    assign t    = {2'b00, slice_thresh};
    assign code = (s >= t) ? SYM_P3 : !s[ACC_W] ? SYM_P1 : (s >= -t) ? SYM_M1 : SYM_M3;

`ifdef RX_ERR_EN
    logic signed [ACC_W:0] t1, t3, ideal;
    assign t1    = t >>> 1;
    assign t3    = t + t1;
    assign ideal = (code == SYM_P3) ? t3 : (code == SYM_P1) ? t1 : (code == SYM_M1) ? -t1 : -t3;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            sym_out <= SYM_M3;
`ifdef RX_ERR_EN
            err     <= '0;
`endif
        end else if (sam_clk_ena) begin
            acc <= sym_clk_ena ? '0 : sum;
            if (sym_clk_ena) begin
                sym_out <= code;
`ifdef RX_ERR_EN
                err     <= s - ideal;
`endif
            end
        end
    end

endmodule

// File: rtl/receiver.sv
// receiver: Fs/4 quadrature receiver - NCO sign-select mixer, integrate-and-dump, 4-level slicer.
//   Optional feature macro: RX_ERR_EN (adds err_i / err_q slicer error outputs).
//   clk, reset_n           : clock, asynchronous active-low reset
//   sam_clk_ena            : sample-rate enable
//   sym_clk_ena            : symbol-rate enable (needs sam_clk_ena in the same cycle)
//   rx_in                  : signed carrier sample
//   phase_offset           : NCO phase alignment added to the phase counter
//   slice_thresh           : unsigned outer decision threshold
//   syms_out_i, syms_out_q : sliced symbols
//   sym_valid              : one-cycle new-symbol strobe
//   err_i, err_q           : (RX_ERR_EN) slicer error per rail
module receiver
    import rx_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sam_clk_ena,
    input  logic                   sym_clk_ena,
    input  logic signed [IN_W-1:0] rx_in,
    input  logic [1:0]             phase_offset,
    input  logic [ACC_W-2:0]       slice_thresh,
    output logic [1:0]             syms_out_i,
    output logic [1:0]             syms_out_q,
    output logic                   sym_valid
`ifdef RX_ERR_EN
    ,
    output logic signed [ACC_W:0]  err_i,
    output logic signed [ACC_W:0]  err_q
`endif
);

    logic [1:0]             cnt, p;
    logic signed [IN_W-1:0] mix_i, mix_q, sel;

    assign p   = cnt + phase_offset;
    // Phases 2 and 3 carry the negated carrier; odd phases feed I, even phases feed Q.
    assign sel = p[1] ? sat_neg(rx_in) : rx_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            mix_i     <= '0;
            mix_q     <= '0;
            sym_valid <= 1'b0;
        end else begin
            cnt       <= cnt + 2'd1;
            sym_valid <= sam_clk_ena && sym_clk_ena;
            if (p[0]) mix_i <= sel;
            else      mix_q <= sel;
        end
    end

    rx_integrate_dump #(.ACC_W(ACC_W)) u_i (
        .clk          (clk),
        .reset_n      (reset_n),
        .sam_clk_ena  (sam_clk_ena),
        .sym_clk_ena  (sym_clk_ena),
        .mix          (mix_i),
        .slice_thresh (slice_thresh),
        .sym_out      (syms_out_i)
`ifdef RX_ERR_EN
        ,
        .err          (err_i)
`endif
    );

    rx_integrate_dump #(.ACC_W(ACC_W)) u_q (
        .clk          (clk),
        .reset_n      (reset_n),
        .sam_clk_ena  (sam_clk_ena),
        .sym_clk_ena  (sym_clk_ena),
        .mix          (mix_q),
        .slice_thresh (slice_thresh),
        .sym_out      (syms_out_q)
`ifdef RX_ERR_EN
        ,
        .err          (err_q)
`endif
    );

endmodule
